// File: rtl/fp16_pkg.sv
// Shared constants and FSM state type for the integer-to-binary16 conversion block.
package fp16_pkg;

    localparam int          EXP_BIAS  = 15;
    localparam int          EXP_W     = 5;
    localparam int          MANT_W    = 10;
    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_norm_round.sv
// Iterative normalizer: one left shift per step until the MSB is set, with
// combinational round-to-nearest-even packing of the normalized operand.
module fp16_norm_round
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] operand,
    input  logic        step,
    output logic        done,
    output logic [15:0] result
);

    logic [15:0]       op;
    logic [3:0]        shifts;
    logic              zero;
    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [MANT_W:0]   mant_sum;
    logic [EXP_W:0]    exp_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= '0;
            shifts <= '0;
            zero   <= 1'b0;
        end else if (start) begin
            op     <= operand;
            shifts <= '0;
            zero   <= (operand == 16'h0000);
        end else if (step && !done) begin
            op     <= {op[14:0], 1'b0};
            shifts <= shifts + 4'd1;
        end
    end

    // A zero operand counts as already normalized so it leaves NORM after one cycle.
    assign done = op[15] | zero;

    always_comb begin
        mant     = op[14:5];
        guard    = op[4];
        sticky   = |op[3:0];
        inc      = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
        exp_r    = 6'(EXP_BIAS + 15) - {2'b00, shifts}
                   + {{EXP_W{1'b0}}, mant_sum[MANT_W]};
        if (zero)
            result = FP16_ZERO;
        else if (exp_r >= 6'd31)
            result = FP16_INF;
        else
            result = {1'b0, exp_r[EXP_W-1:0], mant_sum[MANT_W-1:0]};
    end

endmodule

// File: rtl/fp16_conv_arbiter.sv
// Round-robin front end sharing one iterative uint16 -> binary16 converter
// among N_REQ requesters; results return tagged with the requester index.
module fp16_conv_arbiter
    import fp16_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] win_id;
    logic            win_found;
    logic [15:0]     win_data;
    logic            core_start;
    logic            core_step;
    logic            core_done;
    logic [15:0]     core_result;

    // Search begins just past the last winner so every requester is reached within N_REQ grants.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        win_data  = req_data[16*int'(win_id) +: 16];
        if (!rst && state == IDLE && win_found)
            req_ready[win_id] = 1'b1;
    end

    assign core_start = !rst && state == IDLE && win_found;
    assign core_step  = (state == NORM);

    fp16_norm_round u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (core_start),
        .operand (win_data),
        .step    (core_step),
        .done    (core_done),
        .result  (core_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            grant_id   <= '0;
            out_data   <= FP16_ZERO;
            out_id     <= '0;
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    grant_id   <= win_id;
                    last_grant <= win_id;
                    state      <= NORM;
                end
                NORM: if (core_done) state <= ROUND;
                ROUND: begin
                    out_data <= core_result;
                    out_id   <= grant_id;
                    state    <= RESP;
                end
                RESP: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp16_conv_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized two-requester run scored against an arithmetic binary16 model.
module tb_fp16_conv_arbiter;

    localparam int N_REQ = 2;
    localparam int ID_W  = 1;
    localparam int NRAND = 2000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [16*N_REQ-1:0]  req_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [15:0]          out_data;
    logic [ID_W-1:0]      out_id;
    logic                 busy;

    int checks = 0;
    int failures = 0;

    fp16_conv_arbiter #(.N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        int          lat;
        int          id;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] res;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Value-level model: find the leading one, scale to 11 significant bits,
    // round half to even, then rebias.
    function automatic logic [15:0] ref_fp16(input int x);
        int e, q, sh, rem, half;
        if (x == 0) return 16'h0000;
        e = 0;
        while ((1 << (e + 1)) <= x) e++;
        if (e <= 10) begin
            q = x << (10 - e);
        end else begin
            sh   = e - 10;
            q    = x >> sh;
            rem  = x - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
        end
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e + 15 >= 31) return 16'h7C00;
        return 16'((e + 15) * 1024 + (q - 1024));
    endfunction

    function automatic logic [15:0] rand_op();
        int v;
        case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 15);
            1: v = (1 << $urandom_range(0, 15)) + $urandom_range(0, 2) - 1;
            default: v = $urandom_range(0, 65535);
        endcase
        return 16'(v);
    endfunction

    task automatic convert(input int id, input logic [15:0] val, input logic [15:0] exp_d,
                           input int exp_lat, input string name);
        int t, lat;
        @(negedge clk);
        req_data[16*id +: 16] = val;
        req_valid[id] = 1'b1;
        out_ready = 1'b1;
        #1;
        t = 0;
        while (!req_ready[id] && t < 64) begin
            @(negedge clk); #1; t++;
        end
        check({name, "_grant"}, req_ready[id], 1);
        @(negedge clk);
        req_valid[id] = 1'b0;
        #1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk); #1; lat++;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_id"}, out_id, id);
        if (exp_lat > 0) check({name, "_lat"}, lat, exp_lat);
        @(negedge clk); #1;
        check({name, "_drop"}, out_valid, 0);
    endtask

    vec_t vecs[8];
    exp_t sb[$];

    initial begin
        int gids[4], rids[4], rdat[4];
        int ng, nr, t, hs, done_n, issued, extra;
        logic stable_ok, rdy_seen, onehot_ok;
        logic [N_REQ-1:0] acc;
        exp_t e;

        vecs[0] = '{op: 16'd3,     res: 16'h4200, lat: 16, id: 0};
        vecs[1] = '{op: 16'd0,     res: 16'h0000, lat: 2,  id: 1};
        vecs[2] = '{op: 16'h8000,  res: 16'h7800, lat: 2,  id: 0};
        vecs[3] = '{op: 16'd65504, res: 16'h7BFF, lat: 2,  id: 1};
        vecs[4] = '{op: 16'd65535, res: 16'h7C00, lat: 2,  id: 0};
        vecs[5] = '{op: 16'd2049,  res: 16'h6800, lat: 6,  id: 1};
        vecs[6] = '{op: 16'd2051,  res: 16'h6802, lat: 6,  id: 0};
        vecs[7] = '{op: 16'd1,     res: 16'h3C00, lat: 0,  id: 1};

        // Reset with requests pending: nothing may be granted.
        req_valid = 2'b11;
        req_data  = {16'd9, 16'd9};
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_out_id", out_id, 0);
        check("rst_busy", busy, 0);

        // Contention straight out of reset.
        @(negedge clk);
        rst = 1'b0;
        req_data = {16'd7, 16'd5};
        req_valid = 2'b11;
        out_ready = 1'b1;
        #1;
        ng = 0; nr = 0;
        for (int c = 0; c < 200; c++) begin
            if (|(req_ready & req_valid) && ng < 4) begin
                gids[ng] = req_ready[1] ? 1 : 0;
                ng++;
            end
            if (out_valid && out_ready && nr < 4) begin
                rids[nr] = int'(out_id);
                rdat[nr] = int'(out_data);
                nr++;
            end
            if (nr == 4) break;
            @(negedge clk); #1;
        end
        req_valid = '0;
        check("cont_results", nr, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont_grant%0d", i), gids[i], i % 2);
            check($sformatf("cont_id%0d", i), rids[i], i % 2);
            check($sformatf("cont_data%0d", i), rdat[i], (i % 2 == 0) ? 32'h4500 : 32'h4700);
        end

        for (int i = 0; i < 8; i++)
            convert(vecs[i].id, vecs[i].op, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));

        // Backpressure: stall 10 cycles in RESP with another requester waiting.
        @(negedge clk);
        out_ready = 1'b0;
        req_data[15:0] = 16'd3;
        req_valid = 2'b01;
        #1;
        t = 0;
        while (!req_ready[0] && t < 64) begin @(negedge clk); #1; t++; end
        check("bp_grant", req_ready[0], 1);
        @(negedge clk);
        req_valid = 2'b10;
        req_data[31:16] = 16'd7;
        #1;
        t = 0;
        while (!out_valid && t < 40) begin @(negedge clk); #1; t++; end
        check("bp_valid", out_valid, 1);
        stable_ok = 1'b1; rdy_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_data !== 16'h4200 || out_id !== 1'b0 || !out_valid) stable_ok = 1'b0;
            if (|req_ready) rdy_seen = 1'b1;
            @(negedge clk); #1;
        end
        check("bp_stable", stable_ok, 1);
        check("bp_no_ready", rdy_seen, 0);
        out_ready = 1'b1;
        hs = (out_valid && out_ready) ? 1 : 0;
        @(negedge clk);
        req_valid = '0;
        #1;
        check("bp_drop", out_valid, 0);
        for (int c = 0; c < 5; c++) begin
            if (out_valid && out_ready) hs++;
            @(negedge clk); #1;
        end
        check("bp_once", hs, 1);

        // Reset three cycles into a 17-cycle conversion.
        @(negedge clk);
        req_data[15:0] = 16'd1;
        req_valid = 2'b01;
        #1;
        t = 0;
        while (!req_ready[0] && t < 64) begin @(negedge clk); #1; t++; end
        check("mid_grant", req_ready[0], 1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_out_data", out_data, 16'h0000);
        rst = 1'b0;
        req_data = {16'd7, 16'd5};
        req_valid = 2'b11;
        #1;
        t = 0;
        while (!(|req_ready) && t < 20) begin @(negedge clk); #1; t++; end
        check("mid_first_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = '0;
        #1;
        t = 0;
        while (!out_valid && t < 40) begin @(negedge clk); #1; t++; end
        check("mid_res_data", out_data, 16'h4500);
        check("mid_res_id", out_id, 0);
        @(negedge clk); #1;

        // Randomized two-requester traffic with random consumer stalls.
        acc = '0; done_n = 0; issued = 0; extra = 0; onehot_ok = 1'b1;
        for (int c = 0; c < 60000 && done_n < NRAND; c++) begin
            @(negedge clk);
            for (int r = 0; r < N_REQ; r++)
                if (acc[r]) req_valid[r] = 1'b0;
            acc = '0;
            for (int r = 0; r < N_REQ; r++) begin
                if (!req_valid[r] && issued < NRAND && $urandom_range(0, 3) != 0) begin
                    req_data[16*r +: 16] = rand_op();
                    req_valid[r] = 1'b1;
                    issued++;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    extra++;
                end else begin
                    e = sb.pop_front();
                    check("rnd_data", out_data, e.res);
                    check("rnd_id", out_id, e.id);
                    done_n++;
                end
            end
            if ($countones(req_ready) > 1 || (|(req_ready & ~req_valid))) onehot_ok = 1'b0;
            for (int r = 0; r < N_REQ; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    sb.push_back('{id: r, res: ref_fp16(int'(req_data[16*r +: 16]))});
                    acc[r] = 1'b1;
                end
            end
        end
        check("rnd_count", done_n, NRAND);
        check("rnd_spurious", extra, 0);
        check("rnd_ready_onehot", onehot_ok, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
